cordic_arbiter: RTL and testbench

CORDIC_ARBITER -- requirements
Module: cordic_arbiter

---
 rtl/cordic_arbiter.sv | 146 ++++++++++++++
 tb/tb_cordic_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_arbiter.sv
// -----------------------------------------------------------------------------
// cordic_arbiter
//   Shares one CORDIC vectoring unit between four requesters. A round-robin
//   pointer picks the next requesting channel, its X/Y operands are latched and
//   presented to the CORDIC, the start pulse is issued once the unit is not
//   busy, and the result (or a timeout error) is returned to that channel.
//
// Ports
//   clk, rst_n              : clock (posedge), asynchronous active-low reset
//   req[3:0]                : request level per channel
//   x_req/y_req[63:0]       : four signed 16-bit operands, channel k at [16k+15:16k]
//   ack[3:0]                : one-hot pulse, cycle after operand capture
//   rsp_valid/rsp_err[3:0]  : one-hot completion / timeout pulses
//   rsp_angle/rsp_mag[15:0] : last CORDIC result, held until the next result
//   rsp_chan[1:0]           : channel of the last response, held
//   cordic_start            : one-cycle start pulse to the CORDIC
//   cordic_x/cordic_y[15:0] : captured operands, stable until next capture
//   cordic_angle/mag[15:0]  : CORDIC results
//   cordic_done, cordic_busy: CORDIC completion pulse and busy level
// -----------------------------------------------------------------------------
module cordic_arbiter #(
    parameter int TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [63:0] x_req,
    input  logic [63:0] y_req,
    output logic [3:0]  ack,
    output logic [3:0]  rsp_valid,
    output logic [3:0]  rsp_err,
    output logic [15:0] rsp_angle,
    output logic [15:0] rsp_mag,
    output logic [1:0]  rsp_chan,
    output logic        cordic_start,
    output logic [15:0] cordic_x,
    output logic [15:0] cordic_y,
    input  logic [15:0] cordic_angle,
    input  logic [15:0] cordic_mag,
    input  logic        cordic_done,
    input  logic        cordic_busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // The counter value seen on the edge where it would reach TIMEOUT.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_r;
    logic [1:0]  ptr_r;
    logic [1:0]  grant_r;
    logic [7:0]  tmo_cnt_r;
    logic [2:0]  pick_s;
    logic        pick_vld_s;
    logic [1:0]  pick_idx_s;

    // Round-robin search starting at p; returns {found, index}. Iterating from
    // the farthest offset down lets the nearest requester overwrite the result.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = p + i[1:0];
            if (r[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign pick_s     = rr_pick(req, ptr_r);
    assign pick_vld_s = pick_s[2];
    assign pick_idx_s = pick_s[1:0];

    // Arbitration FSM with all outputs registered; pulses default low each cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            ptr_r        <= 2'd0;
            grant_r      <= 2'd0;
            tmo_cnt_r    <= 8'd0;
            ack          <= 4'b0000;
            rsp_valid    <= 4'b0000;
            rsp_err      <= 4'b0000;
            rsp_angle    <= 16'd0;
            rsp_mag      <= 16'd0;
            rsp_chan     <= 2'd0;
            cordic_start <= 1'b0;
            cordic_x     <= 16'd0;
            cordic_y     <= 16'd0;
        end else begin
            ack          <= 4'b0000;
            rsp_valid    <= 4'b0000;
            rsp_err      <= 4'b0000;
            cordic_start <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pick_vld_s) begin
                        grant_r  <= pick_idx_s;
                        ptr_r    <= pick_idx_s + 2'd1;
                        cordic_x <= x_req[{pick_idx_s, 4'd0} +: 16];
                        cordic_y <= y_req[{pick_idx_s, 4'd0} +: 16];
                        ack      <= 4'b0001 << pick_idx_s;
                        state_r  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // A stray done here belongs to nobody and is ignored.
                    if (!cordic_busy) begin
                        cordic_start <= 1'b1;
                        tmo_cnt_r    <= 8'd0;
                        state_r      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // done is tested first so it wins over a simultaneous expiry.
                    if (cordic_done) begin
                        rsp_angle <= cordic_angle;
                        rsp_mag   <= cordic_mag;
                        rsp_chan  <= grant_r;
                        rsp_valid <= 4'b0001 << grant_r;
                        state_r   <= ST_IDLE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 8'd1;
                        if (tmo_cnt_r == TMO_LAST) begin
                            rsp_chan <= grant_r;
                            rsp_err  <= 4'b0001 << grant_r;
                            state_r  <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_arbiter.sv
module tb_cordic_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  req;
    logic [63:0] x_req;
    logic [63:0] y_req;
    logic [3:0]  ack;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_err;
    logic [15:0] rsp_angle;
    logic [15:0] rsp_mag;
    logic [1:0]  rsp_chan;
    logic        cordic_start;
    logic [15:0] cordic_x;
    logic [15:0] cordic_y;
    logic [15:0] cordic_angle;
    logic [15:0] cordic_mag;
    logic        cordic_done;
    logic        cordic_busy;

    cordic_arbiter #(.TIMEOUT(40)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .x_req(x_req), .y_req(y_req),
        .ack(ack), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .rsp_angle(rsp_angle), .rsp_mag(rsp_mag), .rsp_chan(rsp_chan),
        .cordic_start(cordic_start), .cordic_x(cordic_x), .cordic_y(cordic_y),
        .cordic_angle(cordic_angle), .cordic_mag(cordic_mag),
        .cordic_done(cordic_done), .cordic_busy(cordic_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int chan; logic [15:0] x; logic [15:0] y; int sdelay;} op_t;
    typedef struct {int chan; bit err; logic [15:0] ang; logic [15:0] mag; int lat;} rsp_t;

    op_t  op_q[$];
    rsp_t rsp_q[$];
    int   n_vec = 0, n_bad = 0;
    int   ack_seen = 0, start_seen = 0, rsp_seen = 0;

    // operand table, channel k
    logic [15:0] xs [4] = '{16'd100, 16'hFED4, 16'd16384, 16'hFFFF};
    logic [15:0] ys [4] = '{16'hFFFB, 16'd700, 16'd0, 16'h8000};

    // stub CORDIC controls (stub_lat < 0: never answers)
    int          stub_lat = 3;
    logic [15:0] stub_angle = 16'd0;
    logic [15:0] stub_mag = 16'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic load_operands();
        for (int k = 0; k < 4; k++) begin
            x_req[16*k +: 16] = xs[k];
            y_req[16*k +: 16] = ys[k];
        end
    endtask

    task automatic push_op(input int ch, input int sdelay);
        op_t o;
        o.chan = ch; o.x = xs[ch]; o.y = ys[ch]; o.sdelay = sdelay;
        op_q.push_back(o);
    endtask

    task automatic push_rsp(input int ch, input bit err, input logic [15:0] a,
                            input logic [15:0] m, input int lat);
        rsp_t r;
        r.chan = ch; r.err = err; r.ang = a; r.mag = m; r.lat = lat;
        rsp_q.push_back(r);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_ack"}, ack, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_rsp_angle"}, rsp_angle, 0);
        chk({tag, "_rsp_mag"}, rsp_mag, 0);
        chk({tag, "_rsp_chan"}, rsp_chan, 0);
        chk({tag, "_cordic_start"}, cordic_start, 0);
        chk({tag, "_cordic_x"}, cordic_x, 0);
        chk({tag, "_cordic_y"}, cordic_y, 0);
    endtask

    task automatic wait_rsp(input string tag, input int r0, input int n);
        for (int t = 0; t < 2000 && rsp_seen < r0 + n; t++) @(posedge clk);
        #2;
        chk({tag, "_rsp_count"}, rsp_seen - r0, n);
    endtask

    // hold r until nack grants happened, drop it, then wait for nrsp responses
    task automatic run(input string tag, input logic [3:0] r, input int nack, input int nrsp);
        int a0, r0;
        a0 = ack_seen; r0 = rsp_seen;
        @(negedge clk); req = r;
        for (int t = 0; t < 2000 && ack_seen < a0 + nack; t++) @(posedge clk);
        #2;
        chk({tag, "_ack_count"}, ack_seen - a0, nack);
        @(negedge clk); req = 4'b0000;
        wait_rsp(tag, r0, nrsp);
        repeat (3) @(posedge clk);
    endtask

    // stub CORDIC: done pulses stub_lat edges after the start is observed
    initial begin
        cordic_done = 1'b0; cordic_angle = 16'd0; cordic_mag = 16'd0;
        forever begin
            @(negedge clk);
            if (cordic_start && rst_n && stub_lat > 0) begin
                repeat (stub_lat) @(posedge clk);
                #1;
                cordic_done = 1'b1; cordic_angle = stub_angle; cordic_mag = stub_mag;
                @(posedge clk);
                #1 cordic_done = 1'b0;
            end
        end
    end

    // monitor: pops expected grants and responses as the DUT presents them
    initial begin
        op_t  cur;
        rsp_t e;
        bit   start_pend;
        int   ack_cyc, start_cyc;
        start_pend = 1'b0; ack_cyc = 0; start_cyc = 0;
        cur.chan = 0; cur.x = 16'd0; cur.y = 16'd0; cur.sdelay = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                start_pend = 1'b0;
            end else begin
                if (ack != 4'b0000) begin
                    ack_seen++;
                    if (op_q.size() == 0) begin
                        chk("ack_unexpected", ack, 0);
                    end else begin
                        cur = op_q.pop_front();
                        chk("ack_onehot", ack, 1 << cur.chan);
                        chk("capture_x", cordic_x, cur.x);
                        chk("capture_y", cordic_y, cur.y);
                        chk("ack_during_op", start_pend, 0);
                        ack_cyc = cyc;
                        start_pend = 1'b1;
                    end
                end
                if (cordic_start) begin
                    start_seen++;
                    chk("start_pending", start_pend, 1);
                    chk("start_delay", cyc - ack_cyc, cur.sdelay);
                    chk("start_x", cordic_x, cur.x);
                    chk("start_y", cordic_y, cur.y);
                    start_pend = 1'b0;
                    start_cyc = cyc;
                end
                if (rsp_valid != 4'b0000 || rsp_err != 4'b0000) begin
                    rsp_seen++;
                    if (rsp_q.size() == 0) begin
                        chk("rsp_unexpected", {rsp_valid, rsp_err}, 0);
                    end else begin
                        e = rsp_q.pop_front();
                        chk("rsp_valid", rsp_valid, e.err ? 0 : (1 << e.chan));
                        chk("rsp_err", rsp_err, e.err ? (1 << e.chan) : 0);
                        chk("rsp_chan", rsp_chan, e.chan);
                        chk("rsp_angle", rsp_angle, e.ang);
                        chk("rsp_mag", rsp_mag, e.mag);
                        chk("rsp_latency", cyc - start_cyc, e.lat);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, s0;
        req = 4'b0000; cordic_busy = 1'b0;
        load_operands();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_zero_outputs("reset");
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // channel 2 alone, 18-cycle CORDIC
        stub_lat = 18; stub_angle = 16'd0; stub_mag = 16'd26980;
        push_op(2, 1);
        push_rsp(2, 1'b0, 16'd0, 16'd26980, 19);
        run("single_ch2", 4'b0100, 1, 1);

        // all four held from reset: 0,1,2,3,0
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        stub_lat = 3; stub_angle = 16'h1234; stub_mag = 16'h0777;
        push_op(0, 1); push_op(1, 1); push_op(2, 1); push_op(3, 1); push_op(0, 1);
        for (int k = 0; k < 4; k++) push_rsp(k, 1'b0, 16'h1234, 16'h0777, 4);
        push_rsp(0, 1'b0, 16'h1234, 16'h0777, 4);
        run("rr_all", 4'b1111, 5, 5);

        // channel 3 (ptr=1), busy for 5 cycles after grant, operand changed meanwhile
        stub_lat = 5; stub_angle = 16'hFF00; stub_mag = 16'h0100;
        push_op(3, 6);
        push_rsp(3, 1'b0, 16'hFF00, 16'h0100, 6);
        r0 = rsp_seen;
        @(negedge clk) req = 4'b1000;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            #1;
            if (ack != 4'b0000) break;
        end
        cordic_busy = 1'b1;
        req = 4'b0000;
        x_req[63:48] = 16'h7FFF; y_req[63:48] = 16'h0001;
        repeat (5) @(posedge clk);
        @(negedge clk) cordic_busy = 1'b0;
        wait_rsp("busy_ch3", r0, 1);
        load_operands();
        repeat (3) @(posedge clk);

        // channel 1, CORDIC never answers: error after 40 cycles, result held
        stub_lat = -1;
        push_op(1, 1);
        push_rsp(1, 1'b1, 16'hFF00, 16'h0100, 40);
        run("timeout_ch1", 4'b0010, 1, 1);

        // channel 0 (ptr=2 wraps), done exactly on the expiry edge
        stub_lat = 39; stub_angle = 16'h2000; stub_mag = 16'h3000;
        push_op(0, 1);
        push_rsp(0, 1'b0, 16'h2000, 16'h3000, 40);
        run("done_at_expiry", 4'b0001, 1, 1);

        // ptr=1 with req 1001: grant 3 then wrap to 0
        stub_lat = 2; stub_angle = 16'h0042; stub_mag = 16'h0043;
        push_op(3, 1); push_op(0, 1);
        push_rsp(3, 1'b0, 16'h0042, 16'h0043, 3);
        push_rsp(0, 1'b0, 16'h0042, 16'h0043, 3);
        run("rr_wrap", 4'b1001, 2, 2);

        // reset during WAIT for channel 1 aborts silently
        stub_lat = -1;
        push_op(1, 1);
        r0 = rsp_seen; s0 = start_seen;
        @(negedge clk) req = 4'b0010;
        for (int t = 0; t < 200 && start_seen == s0; t++) @(posedge clk);
        #2;
        chk("abort_start_seen", start_seen - s0, 1);
        req = 4'b0000;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_zero_outputs("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(posedge clk);
        #2;
        chk("abort_no_rsp", rsp_seen - r0, 0);
        stub_lat = 2; stub_angle = 16'h0abc; stub_mag = 16'h0def;
        push_op(0, 1);
        push_rsp(0, 1'b0, 16'h0abc, 16'h0def, 3);
        run("after_abort", 4'b1111, 1, 1);

        chk("ops_left", op_q.size(), 0);
        chk("rsps_left", rsp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
